// File: rtl/hnf_loc_sram_rsp.sv
// hnf_loc_sram_rsp: way-banked tag/state SRAM responder with read-first writes and a fixed pipelined read latency
module hnf_loc_sram_rsp #(
  parameter int INDEX_WIDTH = 10,
  parameter int WAY_NUM     = 16,
  parameter int CLINE_WIDTH = 32,
  parameter int RD_LAT      = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [INDEX_WIDTH-1:0]         index_q,
  input  logic                           rd_en_q,
  input  logic [WAY_NUM-1:0]             wr_ways_q,
  input  logic [CLINE_WIDTH-1:0]         wr_cline_q,
  output logic [CLINE_WIDTH*WAY_NUM-1:0] rd_clines_q,
  output logic                           rd_valid_q,
  output logic                           coll_q
);
  localparam int DEPTH = 2**INDEX_WIDTH;
  localparam int DW    = CLINE_WIDTH*WAY_NUM;
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
    $error("hnf_loc_sram_rsp: RD_LAT must be 1..4");
  end
  logic [DW-1:0]     mem [DEPTH];
  logic [RD_LAT:1]   vld;
  logic [RD_LAT:1]   cl;
  logic [DW-1:0]     dat [1:RD_LAT];
  // per-way array writes; suppressed while in reset
  always_ff @(posedge clk)
    for (int w = 0; w < WAY_NUM; w++)
      if (rst_n && wr_ways_q[w]) mem[index_q][w*CLINE_WIDTH +: CLINE_WIDTH] <= wr_cline_q;
  // read pipeline: stage 1 captures pre-write set contents, data only moves with a valid so the last stage holds
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld <= '0;
      cl  <= '0;
      for (int k = 1; k <= RD_LAT; k++) dat[k] <= '0;
    end else begin
      vld[1] <= rd_en_q;
      cl[1]  <= rd_en_q & (|wr_ways_q);
      if (rd_en_q) dat[1] <= mem[index_q];
      for (int k = 2; k <= RD_LAT; k++) begin
        vld[k] <= vld[k-1];
        cl[k]  <= cl[k-1];
        if (vld[k-1]) dat[k] <= dat[k-1];
      end
    end
  assign rd_valid_q  = vld[RD_LAT];
  assign coll_q      = cl[RD_LAT];
  assign rd_clines_q = dat[RD_LAT];
endmodule

// File: tb/tb_hnf_loc_sram_rsp.sv
// tb_hnf_loc_sram_rsp: scoreboard bench driving three responders (RD_LAT 2, 1, 4) with shared directed requests
module tb_hnf_loc_sram_rsp;
  localparam int IW = 10, WN = 16, CW = 32, DW = CW*WN;
  localparam int LATS [3] = '{2, 1, 4};
  typedef struct {logic [DW-1:0] d; logic c; int cyc;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [IW-1:0] index;
  logic rd_en;
  logic [WN-1:0] wr_ways;
  logic [CW-1:0] wr_cline;
  logic [DW-1:0] rdata [3];
  logic vld [3];
  logic coll [3];
  exp_t sbq [3][$];
  exp_t e;
  int cyc = 0;
  int compared = 0, mismatched = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  hnf_loc_sram_rsp #(.RD_LAT(2)) dut_l2 (.clk(clk), .rst_n(rst_n), .index_q(index), .rd_en_q(rd_en),
    .wr_ways_q(wr_ways), .wr_cline_q(wr_cline), .rd_clines_q(rdata[0]), .rd_valid_q(vld[0]), .coll_q(coll[0]));
  hnf_loc_sram_rsp #(.RD_LAT(1)) dut_l1 (.clk(clk), .rst_n(rst_n), .index_q(index), .rd_en_q(rd_en),
    .wr_ways_q(wr_ways), .wr_cline_q(wr_cline), .rd_clines_q(rdata[1]), .rd_valid_q(vld[1]), .coll_q(coll[1]));
  hnf_loc_sram_rsp #(.RD_LAT(4)) dut_l4 (.clk(clk), .rst_n(rst_n), .index_q(index), .rd_en_q(rd_en),
    .wr_ways_q(wr_ways), .wr_cline_q(wr_cline), .rd_clines_q(rdata[2]), .rd_valid_q(vld[2]), .coll_q(coll[2]));

  function automatic logic [DW-1:0] fill(input logic [CW-1:0] v);
    return {WN{v}};
  endfunction

  // monitor: every response is popped and checked for data, collision flag and latency
  always @(negedge clk) if (rst_n) for (int d = 0; d < 3; d++) if (vld[d]) begin
    if (sbq[d].size() == 0) begin
      compared++; mismatched++;
      $display("FAIL spurious_valid dut_lat%0d cyc=%0d got=%h", LATS[d], cyc, rdata[d]);
    end else begin
      e = sbq[d].pop_front();
      compared += 2;
      if (rdata[d] !== e.d || coll[d] !== e.c) begin
        mismatched++;
        $display("FAIL rsp_data dut_lat%0d got coll=%b data=%h exp coll=%b data=%h", LATS[d], coll[d], rdata[d], e.c, e.d);
      end
      if (cyc != e.cyc + LATS[d]) begin
        mismatched++;
        $display("FAIL rsp_latency dut_lat%0d got cyc=%0d exp cyc=%0d", LATS[d], cyc, e.cyc + LATS[d]);
      end
    end
  end

  task automatic req(input logic [IW-1:0] i, input logic r, input logic [WN-1:0] w,
                     input logic [CW-1:0] c, input logic [DW-1:0] ed, input logic ec);
    exp_t t;
    index = i; rd_en = r; wr_ways = w; wr_cline = c;
    t.d = ed; t.c = ec; t.cyc = cyc;
    if (r) for (int d = 0; d < 3; d++) sbq[d].push_back(t);
    @(posedge clk); #1;
    index = 'x; rd_en = 1'b0; wr_ways = '0; wr_cline = 'x;
  endtask

  initial begin
    logic [DW-1:0] ex;
    index = 'x; rd_en = 1'b0; wr_ways = '0; wr_cline = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      compared++;
      if (vld[d] !== 1'b0 || coll[d] !== 1'b0 || rdata[d] !== '0) begin
        mismatched++;
        $display("FAIL reset_state dut_lat%0d got vld=%b coll=%b data=%h exp all zero", LATS[d], vld[d], coll[d], rdata[d]);
      end
    end
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) req(IW'(i), 1'b0, '1, (i == 5) ? 32'h0 : 32'hC0DE_0000 + i, '0, 1'b0);
    req(10'd9, 1'b0, '1, 32'h11, '0, 1'b0);
    for (int i = 0; i < 8; i++) req(IW'(i), 1'b1, '0, '0, fill((i == 5) ? 32'h0 : 32'hC0DE_0000 + i), 1'b0);
    repeat (6) @(posedge clk); #1;
    for (int w = 0; w < WN; w++) req(10'h3FF, 1'b0, WN'(1) << w, 32'hA5A5_0000 + w, '0, 1'b0);
    for (int w = 0; w < WN; w++) ex[w*CW +: CW] = 32'hA5A5_0000 + w;
    req(10'h3FF, 1'b1, '0, '0, ex, 1'b0);
    req(10'h000, 1'b1, '0, '0, fill(32'hC0DE_0000), 1'b0);
    req(10'd5, 1'b0, 16'h0081, 32'hDEAD_BEEF, '0, 1'b0);
    ex = '0; ex[0 +: CW] = 32'hDEAD_BEEF; ex[7*CW +: CW] = 32'hDEAD_BEEF;
    req(10'd5, 1'b1, '0, '0, ex, 1'b0);
    req(10'd9, 1'b1, '1, 32'h22, fill(32'h11), 1'b1);
    req(10'd9, 1'b1, '0, '0, fill(32'h22), 1'b0);
    repeat (8) @(posedge clk); #1;
    index = 10'd9; rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0; rst_n = 1'b0; wr_ways = '1; wr_cline = 32'h33;
    repeat (2) @(posedge clk); #1;
    wr_ways = '0; rst_n = 1'b1;
    repeat (6) @(posedge clk); #1;
    req(10'd9, 1'b1, '0, '0, fill(32'h22), 1'b0);
    for (int n = 0; n < 20 && (sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0; n++) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      compared++;
      if (sbq[d].size() != 0) begin
        mismatched++;
        $display("FAIL drain dut_lat%0d got %0d outstanding exp 0", LATS[d], sbq[d].size());
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
